// File: rtl/bus_addr_ctrl_8085.sv
// 8085 address demultiplexer and ROM wait-state controller.
// Define BUS_WAIT_EN to enable READY wait-state insertion on ROM reads.
module bus_addr_ctrl_8085 #(
  parameter logic [15:0] ROM_BASE      = 16'h0000,
  parameter int unsigned ROM_SIZE_LOG2 = 11,
  parameter int unsigned WAIT_STATES   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  AD,
  input  logic [7:0]  A_HI,
  input  logic        ALE,
  input  logic        RDn,
  input  logic        WRn,
  input  logic        IO_Mn,
  output logic [15:0] ADD,
  output logic        ROM_SEL,
  output logic        READY,
  output logic        ROM_WR_ERR,
  output logic        BUS_ERR
);

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;

  // Elaboration-time parameter range checks
  if (ROM_SIZE_LOG2 < 1 || ROM_SIZE_LOG2 > 16) begin : g_bad_size
    $error("bus_addr_ctrl_8085: ROM_SIZE_LOG2 out of range");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("bus_addr_ctrl_8085: WAIT_STATES out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
`ifdef BUS_WAIT_EN
    ,
    S_WAIT = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   add_d;
  logic            sel_d;
  logic            wr_err_d;
  logic            bus_err_d;

  logic [AW-1:0]   bus_addr;
  logic [AW-1:0]   win_off;
  logic            in_win;
  logic            rd_only;
  logic            wr_only;
  logic            rd_wr;
  logic            bus_quiet;

  assign bus_addr  = {A_HI, AD};
  assign win_off   = bus_addr - ROM_BASE;
  assign in_win    = ((win_off >> ROM_SIZE_LOG2) == AW'(0));
  assign rd_only   = !RDn &&  WRn;
  assign wr_only   =  RDn && !WRn;
  assign rd_wr     = !RDn && !WRn;
  assign bus_quiet =  RDn &&  WRn;

`ifdef BUS_WAIT_EN
  localparam bit WAIT_ON = (WAIT_STATES != 0);

  logic          ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign READY = ready_q;
`else
  assign READY = 1'b1;
`endif

  // Next-state, address latch and sticky error flag logic
  always_comb begin
    state_d   = state_q;
    add_d     = ADD;
    sel_d     = ROM_SEL;
    wr_err_d  = ROM_WR_ERR;
    bus_err_d = BUS_ERR;
`ifdef BUS_WAIT_EN
    ready_d   = ready_q;
    cnt_d     = cnt_q;
`endif

    if (ALE) begin
      // A new address phase aborts whatever cycle was in progress
      state_d = S_ADDR;
      add_d   = bus_addr;
      sel_d   = !IO_Mn && in_win;
`ifdef BUS_WAIT_EN
      ready_d = 1'b1;
      cnt_d   = CW'(0);
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ADDR: begin
          if (rd_wr) begin
            bus_err_d = 1'b1;
            state_d   = S_IDLE;
`ifdef BUS_WAIT_EN
            ready_d   = 1'b1;
`endif
          end else if (rd_only) begin
            state_d = S_DATA;
`ifdef BUS_WAIT_EN
            if (ROM_SEL && WAIT_ON) begin
              state_d = S_WAIT;
              cnt_d   = CW'(WAIT_STATES);
              ready_d = 1'b0;
            end
`endif
          end else if (wr_only) begin
            state_d = S_DATA;
            if (ROM_SEL) wr_err_d = 1'b1;
          end
        end
`ifdef BUS_WAIT_EN
        S_WAIT: begin
          if (bus_quiet) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            cnt_d   = CW'(0);
          end else if (cnt_q <= CW'(1)) begin
            state_d = S_DATA;
            ready_d = 1'b1;
            cnt_d   = CW'(0);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
`endif
        S_DATA: begin
          if (bus_quiet) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      ADD        <= AW'(0);
      ROM_SEL    <= 1'b0;
      ROM_WR_ERR <= 1'b0;
      BUS_ERR    <= 1'b0;
`ifdef BUS_WAIT_EN
      ready_q    <= 1'b1;
      cnt_q      <= CW'(0);
`endif
    end else begin
      state_q    <= state_d;
      ADD        <= add_d;
      ROM_SEL    <= sel_d;
      ROM_WR_ERR <= wr_err_d;
      BUS_ERR    <= bus_err_d;
`ifdef BUS_WAIT_EN
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_addr_ctrl_8085.sv
// Self-checking bench for bus_addr_ctrl_8085: directed bus cycles plus
// randomized transactions against a transaction-level reference model.
module tb_bus_addr_ctrl_8085;

  localparam logic [15:0] ROM_BASE = 16'h0000;
  localparam int unsigned LOG2     = 11;
  localparam int unsigned WS       = 2;
`ifdef BUS_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  AD = 8'h00;
  logic [7:0]  A_HI = 8'h00;
  logic        ALE = 1'b0;
  logic        RDn = 1'b1;
  logic        WRn = 1'b1;
  logic        IO_Mn = 1'b0;
  logic [15:0] ADD;
  logic        ROM_SEL;
  logic        READY;
  logic        ROM_WR_ERR;
  logic        BUS_ERR;

  bus_addr_ctrl_8085 #(
    .ROM_BASE(ROM_BASE),
    .ROM_SIZE_LOG2(LOG2),
    .WAIT_STATES(WS)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .AD(AD),
    .A_HI(A_HI),
    .ALE(ALE),
    .RDn(RDn),
    .WRn(WRn),
    .IO_Mn(IO_Mn),
    .ADD(ADD),
    .ROM_SEL(ROM_SEL),
    .READY(READY),
    .ROM_WR_ERR(ROM_WR_ERR),
    .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] exp_add;
  bit          exp_sel;
  bit          exp_wr_err;
  bit          exp_bus_err;

  function automatic bit in_window(input logic [15:0] a, input bit io);
    int unsigned off;
    off = (int'(a) - int'(ROM_BASE)) & 32'h0000_FFFF;
    return !io && (off < (32'd1 << LOG2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit exp_ready);
    chk({tag, ".ADD"}, 32'(ADD), 32'(exp_add));
    chk({tag, ".ROM_SEL"}, 32'(ROM_SEL), 32'(exp_sel));
    chk({tag, ".READY"}, 32'(READY), 32'(exp_ready));
    chk({tag, ".ROM_WR_ERR"}, 32'(ROM_WR_ERR), 32'(exp_wr_err));
    chk({tag, ".BUS_ERR"}, 32'(BUS_ERR), 32'(exp_bus_err));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Non-address phases: A_HI/AD/IO_Mn wiggle freely and must not matter
  task automatic scramble();
    A_HI  = 8'($urandom);
    AD    = 8'($urandom);
    IO_Mn = 1'($urandom);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ALE = 1'($urandom); RDn = 1'($urandom); WRn = 1'($urandom);
      scramble();
      tick();
    end
    RESET = 1'b0; ALE = 1'b0; RDn = 1'b1; WRn = 1'b1;
    exp_add = 16'h0000; exp_sel = 1'b0; exp_wr_err = 1'b0; exp_bus_err = 1'b0;
    check_all("reset", 1'b1);
  endtask

  task automatic start_cycle(input logic [15:0] addr, input bit io);
    ALE = 1'b1; A_HI = addr[15:8]; AD = addr[7:0]; IO_Mn = io;
    RDn = 1'b1; WRn = 1'b1;
    tick();
    exp_add = addr;
    exp_sel = in_window(addr, io);
    ALE = 1'b0;
    scramble();
    check_all("ale", 1'b1);
  endtask

  // READY is low for the first WS edges of a held ROM read, high otherwise
  task automatic read_cycle(input int hold);
    RDn = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      scramble();
      check_all("rd", !(WAIT_EN && exp_sel && (k < int'(WS))));
    end
    RDn = 1'b1;
    tick();
    check_all("rd_rel", 1'b1);
    tick();
    check_all("rd_idle", 1'b1);
  endtask

  task automatic write_cycle(input int hold);
    WRn = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (exp_sel) exp_wr_err = 1'b1;
      scramble();
      check_all("wr", 1'b1);
    end
    WRn = 1'b1;
    tick();
    check_all("wr_rel", 1'b1);
  endtask

  task automatic both_cycle();
    RDn = 1'b0; WRn = 1'b0;
    tick();
    exp_bus_err = 1'b1;
    check_all("rdwr", 1'b1);
    RDn = 1'b1; WRn = 1'b1;
    tick();
    check_all("rdwr_rel", 1'b1);
  endtask

  initial begin
    logic [15:0] addr;
    bit          io;
    int          kind;

    exp_add = 16'h0000; exp_sel = 1'b0; exp_wr_err = 1'b0; exp_bus_err = 1'b0;

    do_reset();

    // ROM read with full wait stretch, then one held past the stretch
    start_cycle(16'h0134, 1'b0);
    read_cycle(int'(WS) + 2);

    // Out-of-window memory read and I/O read
    start_cycle(16'h0800, 1'b0);
    read_cycle(3);
    start_cycle(16'h0010, 1'b1);
    read_cycle(3);

    // Write into ROM window, flag stays through later legal cycles
    start_cycle(16'h0100, 1'b0);
    write_cycle(2);
    start_cycle(16'h0010, 1'b1);
    read_cycle(2);
    start_cycle(16'h0900, 1'b0);
    write_cycle(1);
    do_reset();

    // Strobe released after one wait clock
    start_cycle(16'h0134, 1'b0);
    read_cycle(1);

    // ALE while a ROM read is stretched, with RDn still low on that edge
    start_cycle(16'h0134, 1'b0);
    RDn = 1'b0;
    tick();
    check_all("abort_rd", !(WAIT_EN && exp_sel));
    ALE = 1'b1; A_HI = 8'h02; AD = 8'h00; IO_Mn = 1'b0;
    tick();
    exp_add = 16'h0200;
    exp_sel = in_window(16'h0200, 1'b0);
    ALE = 1'b0; RDn = 1'b1;
    scramble();
    check_all("abort_ale", 1'b1);
    tick();
    check_all("abort_addr", 1'b1);
    read_cycle(int'(WS) + 1);

    // Simultaneous strobes
    start_cycle(16'h0042, 1'b0);
    both_cycle();

    // Reset in the middle of a stretched read
    start_cycle(16'h0100, 1'b0);
    RDn = 1'b0;
    tick();
    check_all("rst_wait_pre", !(WAIT_EN && exp_sel));
    RESET = 1'b1;
    tick();
    RESET = 1'b0; RDn = 1'b1;
    exp_add = 16'h0000; exp_sel = 1'b0; exp_wr_err = 1'b0; exp_bus_err = 1'b0;
    check_all("rst_wait", 1'b1);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 15) == 0) do_reset();
      if ($urandom_range(0, 1) == 1)
        addr = 16'(int'(ROM_BASE) + int'($urandom_range(0, (1 << LOG2) - 1)));
      else
        addr = 16'($urandom_range(0, 16'hFFFF));
      io = ($urandom_range(0, 3) == 0);
      start_cycle(addr, io);
      kind = int'($urandom_range(0, 9));
      if (kind < 6)
        read_cycle(int'($urandom_range(1, WS + 2)));
      else if (kind < 9)
        write_cycle(int'($urandom_range(1, 3)));
      else
        both_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_addr_ctrl_8085.md
# bus_addr_ctrl_8085

Address demultiplexer and wait-state controller between the 8085 CPU bus and the program ROM. It latches the low address byte from the multiplexed AD bus on ALE and forms the 16-bit address ADD consumed by the ROM. It decodes the ROM window and stretches ROM read cycles by driving READY low for a programmable number of clocks. It also flags illegal bus activity: writes into ROM space, and simultaneous read/write strobes.

## Interface
- ROM_BASE, 16'h0000: first address of the ROM window.
- ROM_SIZE_LOG2, 11: ROM window size is 2^ROM_SIZE_LOG2 bytes. Legal range 1..16.
- WAIT_STATES, 2: READY-low clocks inserted per ROM read. Legal range 0..15.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  reset, synchronous, active-high.
- AD  input  8  multiplexed address/data bus, observed only; never driven.
- A_HI  input  8  CPU address lines A15..A8.
- ALE  input  1  address latch enable from CPU.
- RDn  input  1  read strobe, active-low.
- WRn  input  1  write strobe, active-low.
- IO_Mn  input  1  1 = I/O cycle, 0 = memory cycle.
- ADD  output  16  latched address to the ROM.
- ROM_SEL  output  1  current cycle is a memory access inside the ROM window.
- READY  output  1  CPU ready input; 0 requests a wait state.
- ROM_WR_ERR  output  1  sticky flag: memory write hit the ROM window.
- BUS_ERR  output  1  sticky flag: RDn and WRn sampled low together.

## Operation
- Reset values: ADD=16'h0000, ROM_SEL=0, READY=1, ROM_WR_ERR=0, BUS_ERR=0, FSM in IDLE, wait counter 0.
- Address latch: on every edge where ALE=1, ADD <= {A_HI, AD}.
- ROM_SEL is registered at the same edge. It is set when IO_Mn=0 and (({A_HI,AD} - ROM_BASE) >> ROM_SIZE_LOG2) == 0, computed as an unsigned 16-bit difference.
- FSM states and transitions:
  - IDLE: ALE=1 -> ADDR.
  - ADDR: wait for a strobe.
    - RDn=0 and WRn=1 with ROM_SEL=1 and WAIT_STATES>0: go to WAIT, load counter with WAIT_STATES, READY <= 0.
    - RDn=0 and WRn=1 otherwise: go to DATA, READY stays 1.
    - WRn=0 and RDn=1: go to DATA; if ROM_SEL=1, set ROM_WR_ERR.
    - RDn=0 and WRn=0: set BUS_ERR, go to IDLE, READY=1.
  - WAIT: decrement the counter each clock. When the counter reaches 1, READY <= 1 and go to DATA.
  - DATA: when RDn=1 and WRn=1, go to IDLE.
- Priority at any edge is RESET > ALE > strobe logic. When ALE=1 in WAIT or DATA, the old cycle is aborted: READY <= 1, counter cleared, new address latched, go to ADDR.
- Strobe released during WAIT (RDn=1 and WRn=1): READY <= 1, go to IDLE, ADD held.
- ROM_WR_ERR and BUS_ERR are cleared only by RESET.

## Timing
- ADD and ROM_SEL become valid on the clock after the edge that samples ALE=1. They hold until the next ALE.
- Strobe sampled low at edge m on a ROM read: READY=0 from after edge m until edge m+WAIT_STATES, so exactly WAIT_STATES low cycles. READY=1 after edge m+WAIT_STATES.
- WAIT_STATES=0: READY never deasserts, and there is no WAIT state.
- I/O cycles and memory accesses outside the window: READY stays 1.
- Error flags assert one clock after the offending sample.
- RESET asserted mid-WAIT: READY=1 and FSM=IDLE after that edge.

## Configuration
- BUS_WAIT_EN defined: wait-state insertion is active as described above.
- BUS_WAIT_EN undefined: the WAIT state and counter are compiled out, READY is tied to 1, and ROM reads go ADDR -> DATA. Address latching, ROM_SEL and both error flags are unchanged.

## Test plan
- Reset: assert RESET for 2 clocks with random bus values -> ADD=0, READY=1, ROM_SEL=0, both error flags 0.
- ROM read, WAIT_STATES=2, window 0x0000-0x07FF: ALE with A_HI=8'h01, AD=8'h34, IO_Mn=0 -> ADD=16'h0134, ROM_SEL=1; RDn low -> READY low for exactly 2 clocks, then 1; RDn high -> IDLE.
- Out-of-window and I/O reads: address 16'h0800 with IO_Mn=0, then address 16'h0010 with IO_Mn=1 -> ROM_SEL=0, READY stays 1 throughout.
- ROM write: ALE at 16'h0100, WRn low -> ROM_WR_ERR=1 one clock later and stays 1 through later legal cycles until RESET.
- Abort cases: release RDn after 1 wait clock -> READY=1 and IDLE. ALE mid-WAIT with address 16'h0200 -> READY=1, ADD=16'h0200. RDn and WRn low together -> BUS_ERR=1.
- Build without BUS_WAIT_EN and repeat scenario 2 -> READY constantly 1 and ADD=16'h0134.
